cpu_regbank_ctrl: RTL and testbench

//  Owns the CPU's 4-bank x 128-bit register bank and shares it between NREQ requesters
//  (execute, stack/interrupt sequencer, debug). Round-robin arbitrated, 2-stage pipeline.
//  Per-access width select: byte/half/word/dword/quad lanes. Sequenced bank-clear command.

---
 rtl/cpu_regbank_ctrl_pkg.sv | 57 +++++
 rtl/cpu_regbank_ctrl_if.sv | 37 +++
 rtl/cpu_regbank_ctrl_rr_arbiter.sv | 45 ++++
 rtl/cpu_regbank_ctrl.sv | 169 ++++++++++++++++
 tb/tb_cpu_regbank_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_regbank_ctrl_pkg.sv
// Shared definitions for the CPU register bank: size codes, tap bank indices, FSM states
// and the lane range/mask/offset helpers used by the access stage.
package cpu_regbank_ctrl_pkg;

  localparam int NBANK  = 4;
  localparam int DW     = 128;
  localparam int BANK_A = 0;
  localparam int BANK_X = 1;
  localparam int BANK_Y = 2;

  localparam logic [2:0] SZ_B = 3'd0;
  localparam logic [2:0] SZ_H = 3'd1;
  localparam logic [2:0] SZ_W = 3'd2;
  localparam logic [2:0] SZ_D = 3'd3;
  localparam logic [2:0] SZ_Q = 3'd4;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  // Index bits above the lane count are not masked: they make the access illegal.
  function automatic logic lane_ok(input logic [2:0] size, input logic [3:0] idx);
    case (size)
      SZ_B:    return 1'b1;
      SZ_H:    return idx < 4'd8;
      SZ_W:    return idx < 4'd4;
      SZ_D:    return idx < 4'd2;
      SZ_Q:    return idx == 4'd0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [2:0] size);
    case (size)
      SZ_B:    return {120'd0, 8'hFF};
      SZ_H:    return {112'd0, 16'hFFFF};
      SZ_W:    return {96'd0, 32'hFFFF_FFFF};
      SZ_D:    return {64'd0, {64{1'b1}}};
      SZ_Q:    return {DW{1'b1}};
      default: return '0;
    endcase
  endfunction

  function automatic logic [6:0] lane_offset(input logic [2:0] size, input logic [3:0] idx);
    logic [6:0] i7;
    i7 = {3'b000, idx};
    case (size)
      SZ_B:    return i7 << 3;
      SZ_H:    return i7 << 4;
      SZ_W:    return i7 << 5;
      SZ_D:    return i7 << 6;
      default: return 7'd0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_regbank_ctrl_if.sv
// Requester-side bus of the register bank: per-requester request fields, grant/completion
// pulses, shared read data, clear command, A/X/Y taps and FSM state for observation.
interface cpu_regbank_ctrl_if #(parameter int NREQ = 3);
  import cpu_regbank_ctrl_pkg::*;

  // Handshake: i_req is a level held with stable fields until o_gnt[r] pulses (the
  // acceptance cycle); o_rvalid[r] (with o_err/o_rdata) follows exactly one cycle later.
  // A request still high the cycle after o_gnt is a fresh request.
  logic [NREQ-1:0]     i_req;
  logic [NREQ-1:0]     i_lock;
  logic [NREQ-1:0]     i_we;
  logic [NREQ*2-1:0]   i_bank;
  logic [NREQ*3-1:0]   i_size;
  logic [NREQ*4-1:0]   i_index;
  logic [NREQ*DW-1:0]  i_wdata;
  logic                i_clr;
  logic [NREQ-1:0]     o_gnt;
  logic [NREQ-1:0]     o_rvalid;
  logic [NREQ-1:0]     o_err;
  logic [DW-1:0]       o_rdata;
  logic                o_busy;
  logic [7:0]          o_a;
  logic [7:0]          o_x;
  logic [7:0]          o_y;
  state_e              o_dbg_state;

  modport master (
    output i_req, i_lock, i_we, i_bank, i_size, i_index, i_wdata, i_clr,
    input  o_gnt, o_rvalid, o_err, o_rdata, o_busy, o_a, o_x, o_y, o_dbg_state
  );

  modport slave (
    input  i_req, i_lock, i_we, i_bank, i_size, i_index, i_wdata, i_clr,
    output o_gnt, o_rvalid, o_err, o_rdata, o_busy, o_a, o_x, o_y, o_dbg_state
  );

endinterface

// File: rtl/cpu_regbank_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among NREQ requests; after a grant to k the search
// starts at k+1. i_freeze holds the pointer (used while a requester owns the bank).
module cpu_regbank_ctrl_rr_arbiter #(
  parameter int NREQ = 3
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic            i_freeze,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [PW-1:0] kk;
  logic          found;
  int            k;

  always_comb begin
    o_gnt   = '0;
    found   = 1'b0;
    ptr_nxt = ptr;
    k       = 0;
    kk      = '0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      kk = PW'(k);
      if (i_en && !found && i_req[kk]) begin
        o_gnt[kk] = 1'b1;
        found     = 1'b1;
        ptr_nxt   = (k == NREQ - 1) ? '0 : PW'(k + 1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                  ptr <= '0;
    else if (found && !i_freeze) ptr <= ptr_nxt;
  end

endmodule

// File: rtl/cpu_regbank_ctrl.sv
// 4 x 128-bit register bank shared by NREQ requesters: grant stage, access stage, lane
// insert/extract, sequenced bank clear. Optional grant lock: define REGBANK_LOCK_EN.
module cpu_regbank_ctrl
  import cpu_regbank_ctrl_pkg::*;
#(
  parameter int NREQ = 3
) (
  input logic               i_clk,
  input logic               i_rst,
  cpu_regbank_ctrl_if.slave bus
);

  state_e          state, state_nxt;
  logic [1:0]      clr_cnt, clr_cnt_nxt;
  logic [DW-1:0]   bank_q [NBANK];

  logic [NREQ-1:0] gnt, arb_req;
  logic            grant_en, clr_req, clr_start, lock_hold;

  logic            sel_we;
  logic [1:0]      sel_bank;
  logic [2:0]      sel_size;
  logic [3:0]      sel_idx;
  logic [DW-1:0]   sel_wdata;

  logic            s2_valid, s2_we;
  logic [NREQ-1:0] s2_gnt;
  logic [1:0]      s2_bank;
  logic [2:0]      s2_size;
  logic [3:0]      s2_idx;
  logic [DW-1:0]   s2_wdata;

  logic            legal;
  logic [DW-1:0]   mask, field, wr_val;
  logic [6:0]      off;

`ifdef REGBANK_LOCK_EN
  logic            lock_act, clr_pend;
  logic [NREQ-1:0] lock_id;

  assign lock_hold = lock_act && |(bus.i_lock & lock_id);
  assign arb_req   = lock_hold ? (bus.i_req & lock_id) : bus.i_req;
  assign clr_req   = bus.i_clr | clr_pend;

  // A clear arriving while a lock is held is remembered until the owner lets go.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      lock_act <= 1'b0;
      lock_id  <= '0;
      clr_pend <= 1'b0;
    end else begin
      lock_act <= lock_hold | (|(gnt & bus.i_lock));
      lock_id  <= lock_hold ? lock_id : gnt;
      clr_pend <= clr_req && !clr_start && (state == ST_IDLE);
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_lock;
  assign lock_hold   = 1'b0;
  assign arb_req     = bus.i_req;
  assign clr_req     = bus.i_clr;
`endif

  assign clr_start = (state == ST_IDLE) && clr_req && !lock_hold;
  assign grant_en  = !i_rst && (state == ST_IDLE) && !clr_start;

  cpu_regbank_ctrl_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (arb_req),
    .i_en     (grant_en),
    .i_freeze (lock_hold),
    .o_gnt    (gnt)
  );

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    case (state)
      ST_IDLE: begin
        if (clr_start) begin
          state_nxt   = ST_CLEAR;
          clr_cnt_nxt = 2'd0;
        end
      end
      ST_CLEAR: begin
        clr_cnt_nxt = clr_cnt + 2'd1;
        if (clr_cnt == 2'd3) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_IDLE;
      clr_cnt <= 2'd0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_bank  = '0;
    sel_size  = '0;
    sel_idx   = '0;
    sel_wdata = '0;
    for (int r = 0; r < NREQ; r++) begin
      if (gnt[r]) begin
        sel_we    = bus.i_we[r];
        sel_bank  = bus.i_bank[r*2 +: 2];
        sel_size  = bus.i_size[r*3 +: 3];
        sel_idx   = bus.i_index[r*4 +: 4];
        sel_wdata = bus.i_wdata[r*DW +: DW];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_valid <= 1'b0;
      s2_gnt   <= '0;
      s2_we    <= 1'b0;
      s2_bank  <= '0;
      s2_size  <= '0;
      s2_idx   <= '0;
      s2_wdata <= '0;
    end else begin
      s2_valid <= |gnt;
      s2_gnt   <= gnt;
      s2_we    <= sel_we;
      s2_bank  <= sel_bank;
      s2_size  <= sel_size;
      s2_idx   <= sel_idx;
      s2_wdata <= sel_wdata;
    end
  end

  assign legal  = lane_ok(s2_size, s2_idx);
  assign mask   = lane_mask(s2_size);
  assign off    = lane_offset(s2_size, s2_idx);
  assign field  = (bank_q[s2_bank] >> off) & mask;
  assign wr_val = (bank_q[s2_bank] & ~(mask << off)) | ((s2_wdata & mask) << off);

  // Clear and stage-2 writes never coincide: no grant is issued once a clear is starting.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int b = 0; b < NBANK; b++) bank_q[b] <= '0;
    end else if (state == ST_CLEAR) begin
      bank_q[clr_cnt] <= '0;
    end else if (s2_valid && s2_we && legal) begin
      bank_q[s2_bank] <= wr_val;
    end
  end

  assign bus.o_gnt       = gnt;
  assign bus.o_rvalid    = s2_valid ? s2_gnt : '0;
  assign bus.o_err       = (s2_valid && !legal) ? s2_gnt : '0;
  assign bus.o_rdata     = (s2_valid && !s2_we && legal) ? field : '0;
  assign bus.o_busy      = (state == ST_CLEAR);
  assign bus.o_a         = bank_q[BANK_A][7:0];
  assign bus.o_x         = bank_q[BANK_X][7:0];
  assign bus.o_y         = bank_q[BANK_Y][7:0];
  assign bus.o_dbg_state = state;

endmodule

// File: tb/tb_cpu_regbank_ctrl.sv
// Bench for cpu_regbank_ctrl: directed vectors with literal expectations plus a per-cycle
// comparison against a behavioural model of arbitration, lane access and bank clear.
module tb_cpu_regbank_ctrl;
  import cpu_regbank_ctrl_pkg::*;

  localparam int NREQ = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_regbank_ctrl_if #(.NREQ(NREQ)) bus ();

  cpu_regbank_ctrl #(.NREQ(NREQ)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [127:0] m_mem [4];
  int           m_last, m_busy;
  logic         m_pv, m_pwe;
  int           m_pid, m_pbank, m_psize, m_pidx;
  logic [127:0] m_pwdata;
`ifdef REGBANK_LOCK_EN
  int           m_owner;
  logic         m_clr_pend;
`endif

  function automatic logic m_legal(int size, int idx);
    return (size <= 4) && (idx < (16 >> size));
  endfunction

  function automatic logic [127:0] m_read(int bnk, int size, int idx);
    logic [127:0] r;
    int w;
    r = '0;
    w = 8 << size;
    for (int b = 0; b < w; b++) r[b] = m_mem[bnk][idx*w + b];
    return r;
  endfunction

  task automatic m_write(int bnk, int size, int idx, logic [127:0] wd);
    int w;
    w = 8 << size;
    for (int b = 0; b < w; b++) m_mem[bnk][idx*w + b] = wd[b];
  endtask

  task automatic m_reset();
    for (int b = 0; b < 4; b++) m_mem[b] = '0;
    m_last = NREQ - 1;
    m_busy = 0;
    m_pv   = 1'b0;
    m_pwe  = 1'b0;
    m_pid  = 0;
`ifdef REGBANK_LOCK_EN
    m_owner    = -1;
    m_clr_pend = 1'b0;
`endif
  endtask

  always @(negedge clk) begin : cmp_p
    int           gk, k;
    logic         hold, clr_rq, clr_go, idle, legal;
    logic [NREQ-1:0] eg, erv, eer;
    logic [127:0] erd;
    if (rst) begin
      chk("rst_gnt", bus.o_gnt, 0);
      chk("rst_rvalid", bus.o_rvalid, 0);
      chk("rst_rdata", bus.o_rdata, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_taps", {bus.o_a, bus.o_x, bus.o_y}, 0);
      m_reset();
    end else begin
      hold   = 1'b0;
      clr_rq = bus.i_clr;
`ifdef REGBANK_LOCK_EN
      hold   = (m_owner >= 0) && bus.i_lock[m_owner];
      clr_rq = clr_rq | m_clr_pend;
`endif
      idle   = (m_busy == 0);
      clr_go = idle && clr_rq && !hold;
      gk = -1;
      if (idle && !clr_go) begin
        if (hold) begin
          if (bus.i_req[m_pid >= 0 ? 0 : 0] || 1'b1) begin
`ifdef REGBANK_LOCK_EN
            if (bus.i_req[m_owner]) gk = m_owner;
`endif
          end
        end else begin
          for (int i = 0; i < NREQ; i++) begin
            k = (m_last + 1 + i) % NREQ;
            if (gk < 0 && bus.i_req[k]) gk = k;
          end
        end
      end
      eg    = (gk >= 0) ? NREQ'(1 << gk) : '0;
      legal = m_legal(m_psize, m_pidx);
      erv   = m_pv ? NREQ'(1 << m_pid) : '0;
      eer   = (m_pv && !legal) ? NREQ'(1 << m_pid) : '0;
      erd   = (m_pv && !m_pwe && legal) ? m_read(m_pbank, m_psize, m_pidx) : '0;
      chk("gnt", bus.o_gnt, eg);
      chk("rvalid", bus.o_rvalid, erv);
      chk("err", bus.o_err, eer);
      chk("rdata", bus.o_rdata, erd);
      chk("busy", bus.o_busy, !idle);
      chk("tap_a", bus.o_a, m_mem[0][7:0]);
      chk("tap_x", bus.o_x, m_mem[1][7:0]);
      chk("tap_y", bus.o_y, m_mem[2][7:0]);
      // advance to the state after the coming clock edge
      if (m_pv && legal && m_pwe) m_write(m_pbank, m_psize, m_pidx, m_pwdata);
      if (!idle) begin
        m_mem[4 - m_busy] = '0;
        m_busy--;
      end else if (clr_go) begin
        m_busy = 4;
      end
`ifdef REGBANK_LOCK_EN
      m_clr_pend = idle && clr_rq && !clr_go;
      if (!hold) m_owner = (gk >= 0 && bus.i_lock[gk]) ? gk : -1;
`endif
      if (gk >= 0 && !hold) m_last = gk;
      m_pv = (gk >= 0);
      if (gk >= 0) begin
        m_pid    = gk;
        m_pwe    = bus.i_we[gk];
        m_pbank  = int'(bus.i_bank[gk*2 +: 2]);
        m_psize  = int'(bus.i_size[gk*3 +: 3]);
        m_pidx   = int'(bus.i_index[gk*4 +: 4]);
        m_pwdata = bus.i_wdata[gk*128 +: 128];
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int r, logic we, int bnk, int size, int idx, logic [127:0] wd);
    bus.i_we[r]              = we;
    bus.i_bank[r*2 +: 2]     = bnk[1:0];
    bus.i_size[r*3 +: 3]     = size[2:0];
    bus.i_index[r*4 +: 4]    = idx[3:0];
    bus.i_wdata[r*128 +: 128] = wd;
    bus.i_req[r]             = 1'b1;
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic access(int r, logic we, int bnk, int size, int idx, logic [127:0] wd,
                        output logic [127:0] rd, output logic er);
    int   cyc;
    logic got;
    cyc = 0;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    set_req(r, we, bnk, size, idx, wd);
    while (!got && cyc < 50) begin
      @(negedge clk);
      if (bus.o_gnt[r]) got = 1'b1;
      else cyc++;
    end
    chk($sformatf("gnt_wait_r%0d", r), got, 1'b1);
    tick();
    bus.i_req[r] = 1'b0;
    if (got) begin
      @(negedge clk);
      chk($sformatf("rvalid_r%0d", r), bus.o_rvalid[r], 1'b1);
      rd = bus.o_rdata;
      er = bus.o_err[r];
      tick();
    end
  endtask

  function automatic int onehot_idx(logic [NREQ-1:0] v);
    int n, k;
    n = 0;
    k = -1;
    for (int i = 0; i < NREQ; i++) if (v[i]) begin n++; k = i; end
    return (n == 1) ? k : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int exp_rr [6] = '{0, 1, 2, 0, 1, 2};
  int exp_lk [4] = '{1, 1, 1, 2};

  initial begin
    logic [127:0] rd;
    logic         er;
    int           g [6];
    int           busy_cycles, first_g, cyc;
    bus.i_req = '0; bus.i_lock = '0; bus.i_we = '0; bus.i_bank = '0;
    bus.i_size = '0; bus.i_index = '0; bus.i_wdata = '0; bus.i_clr = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dbg_state", bus.o_dbg_state, ST_IDLE);
    chk("reset_busy", bus.o_busy, 1'b0);
    rst = 1'b0;
    tick();

    // byte write then read back
    access(0, 1'b1, 0, 0, 0, 128'hA5, rd, er);
    chk("t1_wr_err", er, 1'b0);
    access(0, 1'b0, 0, 0, 0, 128'h0, rd, er);
    chk("t1_rd_byte", rd, 128'hA5);
    chk("t1_tap_a", bus.o_a, 8'hA5);

    // quad all-ones then half lane 3
    access(1, 1'b1, 1, 4, 0, {128{1'b1}}, rd, er);
    access(1, 1'b1, 1, 1, 3, 128'h1234, rd, er);
    access(1, 1'b0, 1, 4, 0, 128'h0, rd, er);
    chk("t2_rd_quad", rd, 128'hFFFF_FFFF_FFFF_FFFF_1234_FFFF_FFFF_FFFF);
    chk("t2_tap_x", bus.o_x, 8'hFF);

    // round robin with all three holding requests
    access(2, 1'b0, 2, 0, 0, 128'h0, rd, er);
    set_req(0, 1'b0, 3, 0, 0, 128'h0);
    set_req(1, 1'b0, 3, 0, 0, 128'h0);
    set_req(2, 1'b0, 3, 0, 0, 128'h0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g[c] = onehot_idx(bus.o_gnt);
    end
    tick();
    bus.i_req = '0;
    for (int c = 0; c < 6; c++) chk($sformatf("t3_rr_%0d", c), g[c], exp_rr[c]);
    tick();

    // illegal sizes / indices, and lane boundaries
    access(0, 1'b0, 0, 2, 4, 128'h0, rd, er);
    chk("t4_w_idx4_err", er, 1'b1);
    chk("t4_w_idx4_rdata", rd, 128'h0);
    access(0, 1'b0, 0, 6, 0, 128'h0, rd, er);
    chk("t4_size6_err", er, 1'b1);
    access(0, 1'b1, 0, 2, 4, {128{1'b1}}, rd, er);
    chk("t4_wr_w_idx4_err", er, 1'b1);
    access(0, 1'b1, 0, 6, 0, {128{1'b1}}, rd, er);
    access(0, 1'b1, 0, 4, 1, {128{1'b1}}, rd, er);
    chk("t4_wr_q_idx1_err", er, 1'b1);
    access(0, 1'b0, 0, 4, 0, 128'h0, rd, er);
    chk("t4_bank0_unchanged", rd, 128'hA5);
    access(2, 1'b1, 2, 0, 15, 128'h3C, rd, er);
    access(2, 1'b0, 2, 3, 1, 128'h0, rd, er);
    chk("t4_b15_via_d1", rd, 128'h3C00_0000_0000_0000);
    chk("t4_d1_err", er, 1'b0);

    // clear with a write in stage 2, then a waiting requester
    for (int b = 0; b < 4; b++) access(0, 1'b1, b, 4, 0, {128{1'b1}}, rd, er);
    set_req(0, 1'b1, 3, 0, 0, 128'h11);
    @(negedge clk);
    chk("t5_wr_gnt", bus.o_gnt[0], 1'b1);
    tick();
    bus.i_req[0] = 1'b0;
    bus.i_clr    = 1'b1;
    @(negedge clk);
    chk("t5_wr_rvalid", bus.o_rvalid[0], 1'b1);
    tick();
    bus.i_clr = 1'b0;
    set_req(2, 1'b0, 3, 4, 0, 128'h0);
    busy_cycles = 0;
    first_g     = -1;
    cyc         = 1;
    while (first_g < 0 && cyc <= 20) begin
      @(negedge clk);
      if (bus.o_busy) busy_cycles++;
      if (bus.o_gnt[2]) first_g = cyc;
      cyc++;
    end
    tick();
    bus.i_req[2] = 1'b0;
    @(negedge clk);
    chk("t5_bank3_after_clear", bus.o_rdata, 128'h0);
    tick();
    chk("t5_busy_cycles", busy_cycles, 4);
    chk("t5_first_grant_cycle", first_g, 5);
    access(1, 1'b0, 0, 4, 0, 128'h0, rd, er);
    chk("t5_bank0_zero", rd, 128'h0);
    access(1, 1'b0, 2, 4, 0, 128'h0, rd, er);
    chk("t5_bank2_zero", rd, 128'h0);

    // reset in the middle of a clear
    access(0, 1'b1, 2, 0, 0, 128'h42, rd, er);
    chk("t6_tap_y_pre", bus.o_y, 8'h42);
    bus.i_clr = 1'b1;
    tick();
    bus.i_clr = 1'b0;
    tick();
    chk("t6_busy_pre", bus.o_busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    chk("t6_busy_rst", bus.o_busy, 1'b0);
    chk("t6_tap_y_rst", bus.o_y, 8'h00);
    chk("t6_dbg_rst", bus.o_dbg_state, ST_IDLE);
    tick();
    rst = 1'b0;
    tick();

    // reset drops an in-flight write
    set_req(0, 1'b1, 0, 0, 0, 128'h77);
    @(negedge clk);
    chk("t6_inflight_gnt", bus.o_gnt[0], 1'b1);
    tick();
    bus.i_req[0] = 1'b0;
    rst = 1'b1;
    #1;
    chk("t6_inflight_rvalid", bus.o_rvalid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t6_inflight_tap_a", bus.o_a, 8'h00);

`ifdef REGBANK_LOCK_EN
    // requester 1 locks the bank while 0 and 2 wait
    access(0, 1'b0, 0, 0, 0, 128'h0, rd, er);
    set_req(0, 1'b0, 1, 0, 0, 128'h0);
    set_req(1, 1'b0, 1, 0, 0, 128'h0);
    set_req(2, 1'b0, 1, 0, 0, 128'h0);
    bus.i_lock[1] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      g[c] = onehot_idx(bus.o_gnt);
      tick();
    end
    bus.i_lock[1] = 1'b0;
    bus.i_req[1]  = 1'b0;
    @(negedge clk);
    g[3] = onehot_idx(bus.o_gnt);
    tick();
    bus.i_req = '0;
    for (int c = 0; c < 4; c++) chk($sformatf("t7_lock_%0d", c), g[c], exp_lk[c]);
    tick();
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
